// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Program store and sequencer that feeds the instruction port of simple_cpu.
// A host loads a program word by word while the unit is idle.  On start the
// unit issues one word per clock from address 0 up to len-1, then pulses done.
// Every cycle without a real program word (idle, stall, halt, done) drives
// NOP_WORD, so the CPU never executes a held instruction twice.
//
// Ports
//   clk          in   system clock, all state on the rising edge
//   rst          in   asynchronous, active-low reset
//   load_en      in   write load_data to load_addr (honoured in IDLE only)
//   load_addr    in   program store write address
//   load_data    in   program word to write
//   len          in   program length in words, sampled when start is accepted
//   start        in   begin execution from address 0 (IDLE only, len != 0)
//   stall        in   freeze sequencing for this cycle
//   halt_req     in   abort the run and return to IDLE
//   instruction  out  registered instruction word to the CPU
//   instr_valid  out  instruction carries a real program word this cycle
//   pc           out  address of the next word to issue
//   busy         out  high while in RUN
//   done         out  one-cycle pulse after the last word was issued
//   fsm_state    out  current sequencer state, for observation only
//
// Handshake: instr_valid is a qualifier with no ready back-pressure.  Each
// cycle instr_valid is high the consumer must take the word on instruction;
// back-pressure from the CPU side is applied through stall before the edge.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                     INSTR_WIDTH = 20,
    parameter int                     PC_BITS     = 5,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en,
    input  logic [PC_BITS-1:0]     load_addr,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic [PC_BITS:0]       len,
    input  logic                   start,
    input  logic                   stall,
    input  logic                   halt_req,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic [PC_BITS-1:0]     pc,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             fsm_state
);

    localparam int DEPTH = 2 ** PC_BITS;

    // DEPTH expressed in the width of len (a single set MSB).
    localparam logic [PC_BITS:0]   DEPTH_W = {1'b1, {PC_BITS{1'b0}}};
    localparam logic [PC_BITS:0]   LEN_ONE = (PC_BITS + 1)'(1);
    localparam logic [PC_BITS-1:0] PC_ONE  = PC_BITS'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // Program store: deliberately not reset so a loaded program survives rst.
    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    logic [PC_BITS:0]       len_q;
    logic [PC_BITS:0]       next_len;
    logic [PC_BITS:0]       len_clamped;
    logic [PC_BITS:0]       last_addr;
    logic [PC_BITS-1:0]     next_pc;
    logic [INSTR_WIDTH-1:0] next_instr;
    logic                   next_valid;
    logic                   next_done;

    // Lengths above DEPTH would only re-issue wrapped addresses; cap them.
    assign len_clamped = (len > DEPTH_W) ? DEPTH_W : len;
    // Only meaningful in RUN, where len_q is guaranteed non-zero.
    assign last_addr   = len_q - LEN_ONE;

    assign busy      = (state == S_RUN);
    assign fsm_state = state;

    // Writes land at the edge and are readable from the following edge on.
    always_ff @(posedge clk) begin
        if (load_en && (state == S_IDLE)) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            len_q       <= '0;
            instruction <= NOP_WORD;
            instr_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= next_state;
            pc          <= next_pc;
            len_q       <= next_len;
            instruction <= next_instr;
            instr_valid <= next_valid;
            done        <= next_done;
        end
    end

    always_comb begin
        next_state = state;
        next_pc    = pc;
        next_len   = len_q;
        next_instr = NOP_WORD;
        next_valid = 1'b0;
        next_done  = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start && (len != '0)) begin
                    next_state = S_RUN;
                    next_pc    = '0;
                    next_len   = len_clamped;
                end
            end

            S_RUN: begin
                if (halt_req) begin
                    next_state = S_IDLE;
                    next_pc    = '0;
                end else if (!stall) begin
                    next_instr = mem[pc];
                    next_valid = 1'b1;
                    // Wraps to 0 when a full-depth program issues its last word.
                    next_pc    = pc + PC_ONE;
                    if ({1'b0, pc} == last_addr) begin
                        next_state = S_DONE;
                    end
                end
            end

            S_DONE: begin
                // start, halt_req and load_en are intentionally not looked at here.
                next_done  = 1'b1;
                next_pc    = '0;
                next_state = S_IDLE;
            end

            default: begin
                next_state = S_IDLE;
                next_pc    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Bench for instr_fetch_unit.  A behavioural program-store model (prog[]) and a
// word counter predict, cycle by cycle, which program word (or NOP) must appear
// on the instruction port, together with pc, busy and done.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int W     = 20;
    localparam int PB    = 5;
    localparam int DEPTH = 32;
    localparam logic [W-1:0] NOP = '0;

    logic          clk;
    logic          rst;
    logic          load_en;
    logic [PB-1:0] load_addr;
    logic [W-1:0]  load_data;
    logic [PB:0]   len;
    logic          start;
    logic          stall;
    logic          halt_req;
    logic [W-1:0]  instruction;
    logic          instr_valid;
    logic [PB-1:0] pc;
    logic          busy;
    logic          done;
    logic [1:0]    fsm_state;

    logic [W-1:0]  prog [DEPTH];
    int            n_cmp;
    int            n_err;

    instr_fetch_unit #(
        .INSTR_WIDTH (W),
        .PC_BITS     (PB),
        .NOP_WORD    (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .len         (len),
        .start       (start),
        .stall       (stall),
        .halt_req    (halt_req),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .fsm_state   (fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver helpers ----------------
    task automatic clear_inputs();
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        len       = '0;
        start     = 1'b0;
        stall     = 1'b0;
        halt_req  = 1'b0;
    endtask

    task automatic load_word(input int addr, input logic [W-1:0] data);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = addr[PB-1:0];
        load_data = data;
        prog[addr] = data;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic load_random_all();
        for (int a = 0; a < DEPTH; a++) begin
            load_word(a, W'($urandom));
        end
    endtask

    // Runs one program and checks every cycle from acceptance to the return to
    // IDLE.  stall_mask bit c stalls the c-th cycle after acceptance; halt_after
    // (>= 0) raises halt_req once that many words have been issued.
    task automatic run_check(input string tag, input int n_len,
                             input logic [63:0] stall_mask, input int halt_after,
                             input bit load_noise, input bit load_with_start);
        int            eff;
        int            k;
        int            cyc;
        bit            finished;
        bit            halted;
        bit            stall_now;
        bit            halt_now;
        logic [W-1:0]  e_instr;
        logic          e_valid;
        logic          e_busy;
        logic [PB-1:0] e_pc;
        logic [27:0]   exp_v;
        logic [27:0]   got_v;

        eff = (n_len > DEPTH) ? DEPTH : n_len;
        @(negedge clk);
        start = 1'b1;
        len   = n_len[PB:0];
        if (load_with_start) begin
            load_en   = 1'b1;
            load_addr = '0;
            load_data = W'($urandom);
            prog[0]   = load_data;
        end
        @(negedge clk);
        start   = 1'b0;
        load_en = 1'b0;
        len     = (PB + 1)'($urandom);
        exp_v = {NOP, 1'b0, 5'd0, 1'b1, 1'b0};
        got_v = {instruction, instr_valid, pc, busy, done};
        n_cmp++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s accept got=%h exp=%h", tag, got_v, exp_v);
        end

        k        = 0;
        finished = 1'b0;
        halted   = 1'b0;
        for (cyc = 0; cyc < 300 && !finished; cyc++) begin
            stall_now = (cyc < 64) ? stall_mask[cyc] : 1'b0;
            halt_now  = (halt_after >= 0) && (k == halt_after);
            stall     = stall_now;
            halt_req  = halt_now;
            if (load_noise) begin
                load_en   = 1'b1;
                load_addr = PB'($urandom);
                load_data = W'($urandom);
            end
            @(negedge clk);
            if (halt_now) begin
                e_instr  = NOP; e_valid = 1'b0; e_pc = '0; e_busy = 1'b0;
                finished = 1'b1;
                halted   = 1'b1;
            end else if (stall_now) begin
                e_instr = NOP; e_valid = 1'b0; e_pc = k[PB-1:0]; e_busy = 1'b1;
            end else begin
                e_instr = prog[k];
                e_valid = 1'b1;
                k++;
                e_pc    = k[PB-1:0];
                e_busy  = (k < eff);
                if (k == eff) finished = 1'b1;
            end
            exp_v = {e_instr, e_valid, e_pc, e_busy, 1'b0};
            got_v = {instruction, instr_valid, pc, busy, done};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL %s cyc%0d got=%h exp=%h", tag, cyc, got_v, exp_v);
            end
        end
        if (!finished) begin
            n_err++;
            $display("FAIL %s timeout issued=%0d exp=%0d", tag, k, eff);
        end

        if (!halted) begin
            // Completion cycle: these requests must all be ignored.
            stall     = $urandom_range(1);
            halt_req  = 1'b1;
            start     = 1'b1;
            len       = 6'd4;
            load_en   = 1'b1;
            load_addr = PB'($urandom);
            load_data = W'($urandom);
            @(negedge clk);
            clear_inputs();
            exp_v = {NOP, 1'b0, 5'd0, 1'b0, 1'b1};
            got_v = {instruction, instr_valid, pc, busy, done};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL %s done got=%h exp=%h", tag, got_v, exp_v);
            end
        end else begin
            clear_inputs();
        end
        @(negedge clk);
        exp_v = {NOP, 1'b0, 5'd0, 1'b0, 1'b0};
        got_v = {instruction, instr_valid, pc, busy, done};
        n_cmp++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s idle_after got=%h exp=%h", tag, got_v, exp_v);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [27:0] got_v;
        clear_inputs();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        got_v = {instruction, instr_valid, pc, busy, done};
        n_cmp++;
        if (got_v !== {NOP, 1'b0, 5'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset got=%h exp=%h", got_v, {NOP, 1'b0, 5'd0, 1'b0, 1'b0});
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        load_word(0, 20'h11111);
        load_word(1, 20'h22222);
        load_word(2, 20'h33333);
        load_word(3, 20'h44444);
        run_check("basic", 4, 64'h0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        // Two stall cycles right after the second word.
        run_check("stall2", 4, 64'hC, -1, 1'b0, 1'b0);
        run_check("stall_rand", 4 + $urandom_range(12),
                  {$urandom, $urandom} & {$urandom, $urandom}, -1, 1'b0, 1'b0);
    endtask

    task automatic test_full_depth();
        load_random_all();
        run_check("full32", 32, 64'h0, -1, 1'b0, 1'b0);
        run_check("clamp40", 40, {$urandom, $urandom} & {$urandom, $urandom},
                  -1, 1'b0, 1'b0);
    endtask

    task automatic test_halt();
        run_check("halt2", 4, 64'h0, 2, 1'b0, 1'b0);
        run_check("halt_stall", 20, {$urandom, $urandom}, 9, 1'b0, 1'b0);
    endtask

    task automatic test_len_zero();
        logic [27:0] got_v;
        @(negedge clk);
        start = 1'b1;
        len   = '0;
        @(negedge clk);
        start = 1'b0;
        got_v = {instruction, instr_valid, pc, busy, done};
        n_cmp++;
        if (got_v !== {NOP, 1'b0, 5'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL len0 got=%h exp=%h", got_v, {NOP, 1'b0, 5'd0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_load_in_run();
        run_check("load_noise", 12, 64'h0, -1, 1'b1, 1'b0);
        run_check("load_verify", 32, 64'h0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_load_with_start();
        run_check("load_start", 3, 64'h0, -1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        logic [27:0] got_v;
        @(negedge clk);
        start = 1'b1;
        len   = 6'd16;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        got_v = {instruction, instr_valid, pc, busy, done};
        n_cmp++;
        if (got_v !== {NOP, 1'b0, 5'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL async_rst got=%h exp=%h", got_v, {NOP, 1'b0, 5'd0, 1'b0, 1'b0});
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        got_v = {instruction, instr_valid, pc, busy, done};
        n_cmp++;
        if (got_v !== {NOP, 1'b0, 5'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL rst_stays_idle got=%h exp=%h", got_v, {NOP, 1'b0, 5'd0, 1'b0, 1'b0});
        end
        run_check("replay", 16, 64'h0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_random_runs();
        int n;
        int h;
        for (int i = 0; i < 8; i++) begin
            n = 1 + $urandom_range(39);
            h = ($urandom_range(1) == 1) ? $urandom_range((n > DEPTH ? DEPTH : n) - 1) : -1;
            run_check("random", n, {$urandom, $urandom} & {$urandom, $urandom},
                      h, $urandom_range(1), $urandom_range(1));
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_stall();
        test_full_depth();
        test_halt();
        test_len_zero();
        test_load_in_run();
        test_load_with_start();
        test_reset_mid_run();
        test_random_runs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
